// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem port, redirect, IF/ID handshake, status
interface fetch_unit_if;
   logic        start;
   logic [31:0] pc_out;
   logic [31:0] instr_in;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_ready;
   logic        halted;
   logic        range_err;
   logic [15:0] fetch_count;

   modport master (
      input  start, instr_in, redirect_valid, redirect_target, id_ready,
      output pc_out, id_valid, id_instr, id_pc, halted, range_err, fetch_count
   );

   modport slave (
      output start, instr_in, redirect_valid, redirect_target, id_ready,
      input  pc_out, id_valid, id_instr, id_pc, halted, range_err, fetch_count
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID register, redirect, halt and PC range trap
module fetch_unit #(
   parameter int unsigned IMEM_DEPTH = 32,
   parameter int unsigned RESET_PC   = 0,
   parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   fetch_unit_if.master bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   localparam logic [31:0] RESET_PC_W = 32'(RESET_PC);
   localparam logic [31:0] DEPTH_W    = 32'(IMEM_DEPTH);

   logic [1:0]  state;
   logic [31:0] pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        halted;
   logic        range_err;
   logic [15:0] fetch_count;

   logic transfer;
   logic load;
   logic pc_in_range;
   logic is_halt_word;

   // Handshake qualifiers: a redirect kills both the transfer and any load this cycle
   always_comb begin
      transfer     = 1'b0;
      load         = 1'b0;
      pc_in_range  = 1'b0;
      is_halt_word = 1'b0;
      transfer     = id_valid & bus.id_ready & ~bus.redirect_valid;
      load         = (state == RUN) & ~bus.redirect_valid & (~id_valid | bus.id_ready);
      pc_in_range  = (pc < DEPTH_W);
      is_halt_word = (bus.instr_in == HALT_WORD);
   end

   // Fetch FSM, PC, IF/ID register and transfer counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= RESET_PC_W;
         id_valid    <= 1'b0;
         id_instr    <= 32'd0;
         id_pc       <= 32'd0;
         halted      <= 1'b0;
         range_err   <= 1'b0;
         fetch_count <= 16'd0;
      end else begin
         if (transfer) begin
            fetch_count <= fetch_count + 16'd1;
         end
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (bus.redirect_valid) begin
                  id_valid <= 1'b0;
                  pc       <= bus.redirect_target;
               end else if (load) begin
                  if (!pc_in_range) begin
                     // Trap: pc holds the offending address for debug
                     id_valid  <= 1'b0;
                     halted    <= 1'b1;
                     range_err <= 1'b1;
                     state     <= HALTED;
                  end else if (is_halt_word) begin
                     // Halt word is consumed, not forwarded; pc stays on it
                     id_valid <= 1'b0;
                     halted   <= 1'b1;
                     state    <= HALTED;
                  end else begin
                     id_instr <= bus.instr_in;
                     id_pc    <= pc;
                     id_valid <= 1'b1;
                     pc       <= pc + 32'd1;
                  end
               end
            end
            HALTED: begin
               if (bus.start) begin
                  pc        <= RESET_PC_W;
                  halted    <= 1'b0;
                  range_err <= 1'b0;
                  state     <= RUN;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.pc_out      = pc;
   assign bus.id_valid    = id_valid;
   assign bus.id_instr    = id_instr;
   assign bus.id_pc       = id_pc;
   assign bus.halted      = halted;
   assign bus.range_err   = range_err;
   assign bus.fetch_count = fetch_count;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory in the KGP-RISC datapath.
- Owns the program counter and drives it to the instruction memory's word-indexed `pc` input. Samples the returned combinational instruction word.
- Registers each fetched instruction and its PC into an IF/ID register, handed to the decoder with a valid/ready handshake.
- Handles branch redirects with flush, decoder backpressure, a halt word, and out-of-range PC trapping.

Parameters:
- IMEM_DEPTH, 32, number of instruction words; legal PC is 0..IMEM_DEPTH-1.
- RESET_PC, 0, word index fetched first after start.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- start  input  1  begin fetching from RESET_PC.
- pc_out  output  32  word index to instruction memory `pc`.
- instr_in  input  32  instruction word from instruction memory `dout` (combinational in pc_out).
- redirect_valid  input  1  taken branch / jump from execute.
- redirect_target  input  32  new word index.
- id_valid  output  1  IF/ID register holds a valid instruction.
- id_instr  output  32  registered instruction.
- id_pc  output  32  PC of id_instr.
- id_ready  input  1  decoder accepts id_instr this cycle.
- halted  output  1  fetch stopped (halt word or range error).
- range_err  output  1  halt caused by out-of-range PC.
- fetch_count  output  16  number of completed id transfers.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=IDLE
  - pc_out=RESET_PC
  - id_valid=0, id_instr=0, id_pc=0
  - halted=0, range_err=0
  - fetch_count=0
- States are IDLE, RUN and HALTED. All transitions occur on a posedge with rst=1.
- Definitions:
  - transfer = id_valid & id_ready & !redirect_valid
  - load = RUN & !redirect_valid & (!id_valid | id_ready)
- fetch_count increments by 1 on every transfer, in any state, and wraps modulo 2^16.
- IDLE:
  - Wait for start=1, then go to RUN. pc_out stays RESET_PC.
  - redirect_valid is ignored.
- RUN, evaluated in priority order:
  1. redirect_valid=1:
     - id_valid<=0 (flush; id_ready ignored, no transfer counted).
     - pc_out<=redirect_target. No capture this cycle.
  2. load and pc_out>=IMEM_DEPTH:
     - No capture. halted<=1, range_err<=1, go to HALTED. pc_out holds.
  3. load and instr_in==HALT_WORD:
     - Halt word is not captured and id_valid<=0.
     - halted<=1, go to HALTED. pc_out holds the halt address.
  4. load otherwise:
     - id_instr<=instr_in, id_pc<=pc_out, id_valid<=1.
     - pc_out<=pc_out+1 (modulo 2^32).
  5. Otherwise (id_valid=1, id_ready=0): all registers hold.
- Latency: start seen at edge N → RUN at N; first capture at edge N+1, giving id_valid=1 and id_pc=RESET_PC. Steady-state throughput is one instruction per cycle while id_ready=1.
- A redirect target that is out of range is accepted; the trap fires on the next load attempt.
- HALTED:
  - No fetch; redirect_valid is ignored.
  - Remaining id_valid can only be present via a halt attempt while the decoder stalls. Under rule 3 it is cleared, so id_valid=0 in HALTED.
  - start=1 → pc_out<=RESET_PC, halted<=0, range_err<=0, go to RUN. fetch_count is not cleared.
- start in RUN is ignored.
- id_instr and id_pc change only on capture. Their values while id_valid=0 are don't-care for the decoder but deterministic (last captured).
- Reset mid-operation: outputs take reset values immediately on rst falling, with no clock needed. Fetch resumes only after rst=1 and a new start.

Test Plan:
- Program words 0..3 = A,B,C,D, word 4 = HALT_WORD, id_ready=1, start pulse at edge 0 → id_pc 0,1,2,3 on edges 1–4 with id_instr A..D; edge 5: id_valid=0, halted=1, range_err=0, pc_out=4; fetch_count=4 after last transfer.
- After id_pc=1 captured, hold id_ready=0 for 3 cycles → id_valid=1, id_pc=1, id_instr=B, pc_out=2 stable, fetch_count unchanged; release → id_pc=2 next edge.
- While id_valid=1, id_pc=5, assert redirect_valid with target=3 and id_ready=1 for one cycle → next edge id_valid=0, pc_out=3, fetch_count unchanged; following edge id_pc=3, id_instr=word 3.
- Memory with no halt word, id_ready=1, start → 32 transfers (id_pc 0..31), then halted=1, range_err=1, pc_out=32, fetch_count=32; start again → pc_out=0, halted=0, range_err=0, fetch resumes.
- Drive rst=0 between clock edges mid-RUN with id_valid=1 → within the same time step id_valid=0, pc_out=0, fetch_count=0, halted=0; with rst=1 and no start, pc_out stays 0 and id_valid stays 0 for 5 cycles.
- Redirect in IDLE and in HALTED (target=7) → no state change, pc_out unchanged.
